// File: rtl/addsub_serial_nb.sv
// Digit-serial two's-complement adder/subtractor with a start/done handshake.
//
// Processes DIGIT bits per clock through a DIGIT-bit ripple chain, LSB digit
// first. An operation takes N = WIDTH/DIGIT cycles in RUN, followed by a
// one-cycle DONE. A start seen in DONE chains straight into the next operation.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  request an operation (sampled in IDLE or DONE only)
//   sub_i    0: num1 + num2, 1: num1 - num2 (sampled with start)
//   num1_i   first operand (sampled with start)
//   num2_i   second operand (sampled with start)
//   busy_o   high while the digit loop is running
//   done_o   one-cycle pulse after a result has been written
//   out_o    result, held between completions
//   cout_o   carry out of the MSB (sub: 1 = no borrow)
//   ovf_o    signed overflow (carry into MSB xor carry out of MSB)
//   zero_o   result is zero
module addsub_serial_nb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : gen_param_check
    $error("addsub_serial_nb: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  // Ripple chain over the low DIGIT bits of A and B.
  // chain[i] is the carry into bit i of the digit; chain[DIGIT] is the carry out.
  logic [DIGIT:0]    chain;
  logic [DIGIT-1:0]  dsum;

  always_comb begin
    chain    = '0;
    dsum     = '0;
    chain[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]    = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Result register shifted right with the new digit entering at the top,
  // so after N digits the LSB digit has reached bit 0.
  logic [WIDTH-1:0] s_shift;

  always_comb begin
    s_shift                    = s_q >> DIGIT;
    s_shift[WIDTH-1 -: DIGIT]  = dsum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_o  = (state_q == StRun);
    done_o  = (state_q == StDone);

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          // Subtraction is num1 + ~num2 + 1: invert B and seed the carry.
          a_d     = num1_i;
          b_d     = sub_i ? ~num2_i : num2_i;
          carry_d = sub_i;
          cnt_d   = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = s_shift;
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          // Last digit: its MSB is the word MSB, so chain[DIGIT-1] is the
          // carry into the word MSB.
          out_d   = s_shift;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT-1] ^ chain[DIGIT];
          zero_d  = (s_shift == '0);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_o  = out_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_addsub_serial_nb.sv
// Scoreboard bench for addsub_serial_nb over several WIDTH/DIGIT pairs.
// Each instance has its own stimulus process pushing expected results and a
// monitor that pops and compares whenever done is seen.
module tb_addsub_serial_nb;

  localparam int NI   = 5;
  localparam int NOPS = 1000;
  localparam int unsigned WS [NI] = '{8, 8, 16, 5, 5};
  localparam int unsigned DS [NI] = '{1, 4, 2, 1, 5};

  // Directed operations {sub, num1, num2}
  localparam logic [16:0] DIR [6] = '{
    {1'b1, 8'h05, 8'h03},
    {1'b1, 8'h03, 8'h05},
    {1'b0, 8'h7F, 8'h01},
    {1'b0, 8'hFF, 8'h01},
    {1'b1, 8'h80, 8'h01},
    {1'b0, 8'h5A, 8'h3C}
  };

  typedef struct packed {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
    int unsigned dcyc;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          fin [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h want 0x%0h (t=%0t)", nm, inst, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int unsigned w, input logic s, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t   e;
    longint lim, ua, ub, sa, sb, r, u;
    lim = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    if (s) begin
      r      = sa - sb;
      u      = ua - ub + lim;
      e.cout = (ua >= ub);
    end else begin
      r      = sa + sb;
      u      = ua + ub;
      e.cout = (u >= lim);
    end
    e.out  = 16'(u % lim);
    e.ovf  = (r >= lim / 2) || (r < -(lim / 2));
    e.zero = ((u % lim) == 0);
    e.dcyc = 0;
    return e;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int unsigned W    = WS[k];
    localparam int unsigned D    = DS[k];
    localparam int unsigned N    = W / D;
    localparam logic [15:0] MASK = 16'((32'd1 << W) - 1);

    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         zero;

    exp_t q [$];
    exp_t held;

    addsub_serial_nb #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .start_i(start),
      .sub_i  (sub),
      .num1_i (num1),
      .num2_i (num2),
      .busy_o (busy),
      .done_o (done),
      .out_o  (out),
      .cout_o (cout),
      .ovf_o  (ovf),
      .zero_o (zero)
    );

    task automatic gen_op(input int idx, output logic s, output logic [15:0] a,
                          output logic [15:0] b);
      logic [16:0] v;
      if (idx < 6) begin
        v = DIR[idx];
        s = v[16];
        a = {8'h00, v[15:8]};
        b = {8'h00, v[7:0]};
      end else begin
        s = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      a = a & MASK;
      b = b & MASK;
    endtask

    task automatic drive_op(input logic s, input logic [15:0] a, input logic [15:0] b);
      start = 1'b1;
      sub   = s;
      num1  = a[W-1:0];
      num2  = b[W-1:0];
    endtask

    // Called at the negedge after the accept edge; cyc then names that edge.
    task automatic push_op(input logic s, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e      = model(W, s, a, b);
      e.dcyc = cyc + N;
      q.push_back(e);
    endtask

    task automatic wait_idle();
      int n = 0;
      while (busy && n < 4 * N + 10) begin
        @(negedge clk);
        n++;
      end
      chk("idle_timeout", k, 32'(busy), 0);
    endtask

    task automatic wait_done();
      int n = 0;
      while (!done && n < 4 * N + 10) begin
        @(negedge clk);
        n++;
      end
      chk("done_timeout", k, 32'(done), 1);
    endtask

    initial begin
      logic        s;
      logic [15:0] a, b;
      bit          pend;
      int          mode;
      pend  = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      num1  = '0;
      num2  = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NOPS; i++) begin
        if (!pend) begin
          gen_op(i, s, a, b);
          wait_idle();
          drive_op(s, a, b);
          @(posedge clk);
          @(negedge clk);
          push_op(s, a, b);
        end
        pend = 1'b0;

        if (i == 8) begin
          // Abort mid-operation with an asynchronous reset.
          @(posedge clk);
          @(posedge clk);
          #1 rst_n = 1'b0;
          start = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          @(negedge clk);
          continue;
        end

        if (i < 6)       mode = 1;
        else if (i == 6) mode = 0;
        else if (i == 7) mode = 2;
        else             mode = $urandom_range(0, 3);

        case (mode)
          0: begin
            if (i + 1 < NOPS) begin
              // Hold start through RUN; accepted on the DONE edge.
              gen_op(i + 1, s, a, b);
              drive_op(s, a, b);
              wait_done();
              @(posedge clk);
              @(negedge clk);
              push_op(s, a, b);
              pend = 1'b1;
            end else begin
              start = 1'b0;
            end
          end
          2: begin
            // Start pulse with junk operands during RUN must be ignored.
            start = 1'b1;
            sub   = 1'($urandom_range(0, 1));
            num1  = W'($urandom);
            num2  = W'($urandom);
            @(negedge clk);
            start = 1'b0;
          end
          3: begin
            start = 1'b0;
            wait_idle();
            repeat ($urandom_range(1, 3)) @(negedge clk);
          end
          default: begin
            start = 1'b0;
            num1  = W'($urandom);
            num2  = W'($urandom);
          end
        endcase
      end

      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      fin[k] = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q.delete();
        held = '0;
        chk("reset_out", k, 32'(out), 0);
        chk("reset_flags", k, 32'({busy, done, cout, ovf, zero}), 0);
      end else if (done) begin
        chk("done_expected", k, 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", k, 32'({16'(out), cout, ovf, zero}), 32'({e.out, e.cout, e.ovf, e.zero}));
          chk("latency", k, cyc, e.dcyc);
          held = e;
        end
      end else begin
        chk("hold", k, 32'({16'(out), cout, ovf, zero}),
            32'({held.out, held.cout, held.ovf, held.zero}));
      end
      chk("busy_done_excl", k, 32'(busy & done), 0);
    end
  end

  initial begin
    int unsigned t;
    bit          all;
    t   = 0;
    all = 1'b0;
    while (!all && t < 80000) begin
      @(posedge clk);
      t++;
      all = 1'b1;
      for (int i = 0; i < NI; i++) if (!fin[i]) all = 1'b0;
    end
    chk("finish_timeout", -1, 32'(all), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
